msg_encryptor: RTL and testbench

- Parameterised Vigenère-style byte encryptor: a MSG_LEN-byte plaintext buffer and a SEC_LEN-byte key buffer are loaded through write ports, then encrypted one byte per clock on start.
- Sits between a host/register front-end that loads message and key, and any consumer of the parallel ciphertext bus text_out.
- Produces uppercase-alphabet ciphertext as 8-bit ASCII codes.

---
 rtl/msg_encryptor.sv | 135 +++++++++++++
 tb/tb_msg_encryptor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_encryptor.sv
// Vigenere-style byte encryptor: loads a plaintext and key buffer, then emits
// one uppercase-shifted ciphertext byte per clock into a parallel output bus.
module msg_encryptor #(
    parameter int MSG_LEN = 22,
    parameter int SEC_LEN = 3,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg_wr,
    input  logic [AW-1:0]        msg_addr,
    input  logic [7:0]           msg_data,
    input  logic                 key_wr,
    input  logic [KW-1:0]        key_addr,
    input  logic [7:0]           key_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    output logic [MSG_LEN*8-1:0] text_out
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(MSG_LEN - 1);
    localparam logic [KW-1:0] LAST_KEY = KW'(SEC_LEN - 1);
    localparam logic [AW:0]   MSG_LIM  = (AW + 1)'(MSG_LEN);
    localparam logic [KW:0]   KEY_LIM  = (KW + 1)'(SEC_LEN);

    // Shift uppercase letters by the key amount; everything else passes through.
    function automatic logic [7:0] enc_byte(input logic [7:0] p, input logic [7:0] k);
        logic [5:0] s;
        logic [5:0] sum;
        logic [7:0] r;
        if ((k >= 8'd65) && (k <= 8'd90)) begin
            s = 6'(k - 8'd65);
        end else begin
            s = 6'(k % 8'd26);
        end
        if ((p >= 8'd65) && (p <= 8'd90)) begin
            sum = 6'(p - 8'd65) + s;
            if (sum >= 6'd26) begin
                sum = sum - 6'd26;
            end else begin
                sum = sum;
            end
            r = 8'd65 + {2'b00, sum};
        end else begin
            r = p;
        end
        return r;
    endfunction

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic [KW-1:0]   r_kidx;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic [7:0]      r_text_in [MSG_LEN];
    logic [7:0]      r_secret  [SEC_LEN];
    logic [7:0]      r_out     [MSG_LEN];

    logic            w_msg_addr_ok;
    logic            w_key_addr_ok;
    logic [7:0]      w_enc;

    assign w_msg_addr_ok = ({1'b0, msg_addr} < MSG_LIM);
    assign w_key_addr_ok = ({1'b0, key_addr} < KEY_LIM);
    assign w_enc         = enc_byte(r_text_in[r_idx], r_secret[r_kidx]);

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_valid;

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_out
        assign text_out[8*g +: 8] = r_out[g];
    end

    // Buffer loading, encryption sequencing and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_kidx  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_text_in[i] <= 8'd0;
                r_out[i]     <= 8'd0;
            end
            for (int j = 0; j < SEC_LEN; j++) begin
                r_secret[j] <= 8'd0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (msg_wr && w_msg_addr_ok) begin
                        r_text_in[msg_addr] <= msg_data;
                    end
                    if (key_wr && w_key_addr_ok) begin
                        r_secret[key_addr] <= key_data;
                    end
                    if (start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_kidx  <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_out[r_idx] <= w_enc;
                    r_kidx <= (r_kidx == LAST_KEY) ? '0 : r_kidx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_encryptor.sv
// Self-checking bench for msg_encryptor: directed scenarios plus random
// messages/keys compared against an arithmetic reference cipher.
module tb_msg_encryptor;

    localparam int MSG_LEN = 22;
    localparam int SEC_LEN = 3;
    localparam int AW = 5;
    localparam int KW = 2;
    localparam int OW = MSG_LEN * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          msg_wr = 1'b0;
    logic [AW-1:0] msg_addr = '0;
    logic [7:0]    msg_data = 8'd0;
    logic          key_wr = 1'b0;
    logic [KW-1:0] key_addr = '0;
    logic [7:0]    key_data = 8'd0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [OW-1:0] text_out;

    int checks = 0;
    int errors = 0;
    int msg_m [MSG_LEN];
    int key_m [SEC_LEN];

    msg_encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
        .clk(clk), .rst(rst),
        .msg_wr(msg_wr), .msg_addr(msg_addr), .msg_data(msg_data),
        .key_wr(key_wr), .key_addr(key_addr), .key_data(key_data),
        .start(start), .busy(busy), .done(done), .out_valid(out_valid),
        .text_out(text_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int ref_enc(input int p, input int k);
        int s;
        s = (k >= 65 && k <= 90) ? (k - 65) : (k % 26);
        if (p >= 65 && p <= 90) return 65 + ((p - 65 + s) % 26);
        return p;
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic [OW-1:0] r;
        for (int i = 0; i < MSG_LEN; i++) r[8*i +: 8] = 8'(ref_enc(msg_m[i], key_m[i % SEC_LEN]));
        return r;
    endfunction

    function automatic logic [OW-1:0] pack_plain();
        logic [OW-1:0] r;
        for (int i = 0; i < MSG_LEN; i++) r[8*i +: 8] = 8'(msg_m[i]);
        return r;
    endfunction

    function automatic logic [OW-1:0] pack_str(input string s);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < MSG_LEN; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic write_msg(input int a, input int d);
        logic [31:0] av;
        av = 32'(a);
        msg_wr = 1'b1; msg_addr = av[AW-1:0]; msg_data = 8'(d);
        if (a < MSG_LEN) msg_m[a] = d;
        tick();
        msg_wr = 1'b0;
    endtask

    task automatic write_key(input int a, input int d);
        logic [31:0] av;
        av = 32'(a);
        key_wr = 1'b1; key_addr = av[KW-1:0]; key_data = 8'(d);
        if (a < SEC_LEN) key_m[a] = d;
        tick();
        key_wr = 1'b0;
    endtask

    task automatic load_msg(input string s);
        for (int i = 0; i < s.len(); i++) write_msg(i, int'(s[i]));
    endtask

    task automatic load_key(input string s);
        for (int i = 0; i < s.len(); i++) write_key(i, int'(s[i]));
    endtask

    // Start an encryption (any writes already set up share the start cycle) and check completion.
    task automatic do_run(input string tag);
        logic [OW-1:0] exp;
        int cnt;
        bit seen;
        exp = model_out();
        start = 1'b1;
        tick();
        start = 1'b0; msg_wr = 1'b0; key_wr = 1'b0;
        check({tag, "_busy_rise"}, OW'(busy), OW'(1));
        check({tag, "_valid_drop"}, OW'(out_valid), OW'(0));
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 100) begin
            tick();
            cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, OW'(cnt), OW'(MSG_LEN));
        check({tag, "_text"}, text_out, exp);
        check({tag, "_busy_fall"}, OW'(busy), OW'(0));
        check({tag, "_valid"}, OW'(out_valid), OW'(1));
        tick();
        check({tag, "_done_pulse"}, OW'(done), OW'(0));
        check({tag, "_valid_hold"}, OW'(out_valid), OW'(1));
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        logic [OW-1:0] golden;

        for (int i = 0; i < MSG_LEN; i++) msg_m[i] = 0;
        for (int i = 0; i < SEC_LEN; i++) key_m[i] = 0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_done", OW'(done), OW'(0));
        check("rst_valid", OW'(out_valid), OW'(0));
        check("rst_text", text_out, '0);
        rst = 1'b0;
        tick();

        golden = pack_str("RIJVSRRMQSWYDIQDQCCWYQ");
        load_msg("HELLOTHISISATESTMESSAG");
        load_key("KEY");
        do_run("full");
        check("full_golden", text_out, golden);

        // Start, writes and key writes during RUN must all be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= MSG_LEN + 4; cyc++) begin
            if (cyc >= 3 && cyc <= 6) begin
                start = 1'b1;
                msg_wr = 1'b1; msg_addr = AW'(cyc); msg_data = 8'd90;
                key_wr = 1'b1; key_addr = '0; key_data = 8'd66;
            end else begin
                start = 1'b0; msg_wr = 1'b0; key_wr = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
        check("ign_done_count", OW'(done_cnt), OW'(1));
        check("ign_done_cycle", OW'(done_cyc), OW'(MSG_LEN));
        check("ign_text", text_out, golden);

        // Out-of-range addresses are dropped; then wrap and pass-through bytes.
        for (int a = MSG_LEN; a < 32; a++) write_msg(a, 65);
        write_key(3, 90);
        load_msg("Z9a");
        load_key("BBB");
        do_run("wrap");
        check("wrap_b0", OW'(text_out[7:0]), OW'(65));
        check("wrap_b1", OW'(text_out[15:8]), OW'(57));
        check("wrap_b2", OW'(text_out[23:16]), OW'(97));

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < MSG_LEN; i++)
                write_msg(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(65, 90)));
            for (int i = 0; i < SEC_LEN; i++)
                write_key(i, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(65, 90)));
            if (r == 2) begin
                // Write coincident with start must be used by this run.
                msg_wr = 1'b1; msg_addr = AW'(MSG_LEN - 1); msg_data = 8'd81; msg_m[MSG_LEN - 1] = 81;
                key_wr = 1'b1; key_addr = '0; key_data = 8'd77; key_m[0] = 77;
            end
            do_run($sformatf("rand%0d", r));
        end

        // Back-to-back: constant key 'A' reproduces the plaintext.
        load_key("AAA");
        check("b2b_valid_held", OW'(out_valid), OW'(1));
        do_run("b2b");
        check("b2b_plain", text_out, pack_plain());

        // Reset mid-run clears everything; rerun encrypts the zeroed buffers.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy_before", OW'(busy), OW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) msg_m[i] = 0;
        for (int i = 0; i < SEC_LEN; i++) key_m[i] = 0;
        check("mid_busy", OW'(busy), OW'(0));
        check("mid_done", OW'(done), OW'(0));
        check("mid_valid", OW'(out_valid), OW'(0));
        check("mid_text", text_out, '0);
        do_run("zero");
        check("zero_text", text_out, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
